load_store_unit: RTL

Multi-cycle load/store unit between the core's execute stage and the word-organised data memory. It accepts one RV32I load or store per transaction. Byte and halfword stores become read-modify-write sequences, because the memory has only a full-word write enable. Loaded bytes and halfwords are extracted and sign- or zero-extended. One response pulse is returned per request.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and word-memory port of the load/store unit.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req;
   logic              wr;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_we;
   logic [31:0]       mem_wd;
   logic [31:0]       mem_rd;

   // Handshake: a request is taken on the rising edge where req=1 and ready=1;
   // the requester keeps req/wr/funct3/addr/wdata stable until then, and done pulses once per request.
   modport slave (
      input  req, wr, funct3, addr, wdata, mem_rd,
      output ready, done, rdata, err, mem_a, mem_we, mem_wd
   );

   modport master (
      output req, wr, funct3, addr, wdata, mem_rd,
      input  ready, done, rdata, err, mem_a, mem_we, mem_wd
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a full-word-write data memory; sub-word stores become read-modify-write.
// Optional build macro: LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses with err.
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   load_store_unit_if.slave    bus,
   output logic [1:0]          fsm_state
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t            state, state_nxt;
   logic              wr_q;
   logic [2:0]        funct3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       merge_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              illegal;
   logic              misalign;
   logic              reject;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       load_val;
   logic [31:0]       merge_val;
   logic              mem_we;
   logic [31:0]       mem_wd;

   assign illegal = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11) || (wr_q && funct3_q[2]);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                     ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign reject = illegal || misalign;

   always_comb begin
      byte_v = bus.mem_rd[7:0];
      case (addr_q[1:0])
         2'd1:    byte_v = bus.mem_rd[15:8];
         2'd2:    byte_v = bus.mem_rd[23:16];
         2'd3:    byte_v = bus.mem_rd[31:24];
         default: byte_v = bus.mem_rd[7:0];
      endcase
      half_v = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

      // funct3[2] selects zero extension (BU/HU)
      case (funct3_q[1:0])
         2'b00:   load_val = {{24{~funct3_q[2] & byte_v[7]}}, byte_v};
         2'b01:   load_val = {{16{~funct3_q[2] & half_v[15]}}, half_v};
         default: load_val = bus.mem_rd;
      endcase

      merge_val = bus.mem_rd;
      if (funct3_q[1:0] == 2'b00) begin
         case (addr_q[1:0])
            2'd0:    merge_val[7:0]   = wdata_q[7:0];
            2'd1:    merge_val[15:8]  = wdata_q[7:0];
            2'd2:    merge_val[23:16] = wdata_q[7:0];
            default: merge_val[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merge_val[31:16] = wdata_q[15:0];
      end else begin
         merge_val[15:0] = wdata_q[15:0];
      end
   end

   always_comb begin
      state_nxt = state;
      mem_we    = 1'b0;
      mem_wd    = '0;
      case (state)
         IDLE: begin
            if (bus.req) state_nxt = ACCESS;
         end
         ACCESS: begin
            if (reject || !wr_q) begin
               state_nxt = RESP;
            end else if (funct3_q[1:0] == 2'b10) begin
               mem_we    = 1'b1;
               mem_wd    = wdata_q;
               state_nxt = RESP;
            end else begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_wd    = merge_q;
            state_nxt = RESP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wr_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merge_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.req) begin
            wr_q     <= bus.wr;
            funct3_q <= bus.funct3;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
         end
         if (state == ACCESS) begin
            err_q <= reject;
            if (!reject && !wr_q) rdata_q <= load_val;
            if (!reject && wr_q)  merge_q <= merge_val;
         end
      end
   end

   // Write enable comes straight from state so an asynchronous reset removes it at once.
   assign bus.mem_we = mem_we;
   assign bus.mem_wd = mem_wd;
   assign bus.mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.ready  = (state == IDLE);
   assign bus.done   = (state == RESP);
   assign bus.err    = (state == RESP) && err_q;
   assign bus.rdata  = rdata_q;
   assign fsm_state  = state;

endmodule
